// File: rtl/adc_spi_pkg.sv
// Shared constants and types for the ADC SPI responder.
// Frame layout: LEAD_ZEROS zero bits, then the sample MSB first.
package adc_spi_pkg;

  localparam int FRAME_BITS     = 16;
  localparam int LEAD_ZEROS     = 4;
  localparam int ADDR_FIRST_BIT = 2;
  localparam int ADDR_BITS      = 3;
  localparam int CNT_W          = $clog2(FRAME_BITS);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

endpackage

// File: rtl/spi_input_sync.sv
// STAGES-deep flop synchronizer for one SPI input pin.
// Ports: clk, rst_n (async low), d (async pin), q (synchronized).
module spi_input_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_d;
  logic [STAGES-1:0] sync_q;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/adc_spi_responder.sv
// SPI mode-0 slave emulating an 8-channel 12-bit serial ADC.
// Ports: i_Clk/i_Rst_L, SPI pins in, i_Samples bus, MISO/enable, channel, done.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_SPI_Clk,
  input  logic                     i_SPI_CS_n,
  input  logic                     i_SPI_MOSI,
  input  logic [NUM_CH*DATA_W-1:0] i_Samples,
  output logic                     o_SPI_MISO,
  output logic                     o_MISO_En,
  output logic [ADDR_BITS-1:0]     o_Channel,
  output logic                     o_Frame_Done
);

  localparam logic [CNT_W-1:0] ADDR_LO =
    CNT_W'(ADDR_FIRST_BIT);
  localparam logic [CNT_W-1:0] ADDR_HI =
    CNT_W'(ADDR_FIRST_BIT + ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT =
    CNT_W'(FRAME_BITS - 1);

  logic cs_s;
  logic sclk_s;
  logic mosi_s;

  spi_input_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync_cs (
    .clk  (i_Clk),
    .rst_n(i_Rst_L),
    .d    (i_SPI_CS_n),
    .q    (cs_s)
  );

  spi_input_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync_sclk (
    .clk  (i_Clk),
    .rst_n(i_Rst_L),
    .d    (i_SPI_Clk),
    .q    (sclk_s)
  );

  spi_input_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync_mosi (
    .clk  (i_Clk),
    .rst_n(i_Rst_L),
    .d    (i_SPI_MOSI),
    .q    (mosi_s)
  );

  state_e                state_d, state_q;
  logic [FRAME_BITS-1:0] shift_d, shift_q;
  logic [CNT_W-1:0]      bit_cnt_d, bit_cnt_q;
  logic [ADDR_BITS-1:0]  addr_sh_d, addr_sh_q;
  logic [ADDR_BITS-1:0]  chan_d, chan_q;
  logic                  reload_d, reload_q;
  logic                  en_d, en_q;
  logic                  done_d, done_q;
  logic                  cs_prev_q;
  logic                  sclk_prev_q;

  logic                  cs_fall;
  logic                  cs_rise;
  logic                  ev_rise;
  logic                  ev_fall;
  logic                  in_addr;
  logic [DATA_W-1:0]     sel_sample;
  logic [FRAME_BITS-1:0] load_word;

  // CS edges outrank SCLK edges seen in the same cycle.
  assign cs_fall = cs_prev_q & ~cs_s;
  assign cs_rise = ~cs_prev_q & cs_s;
  assign ev_rise = (state_q == ACTIVE) & sclk_s & ~sclk_prev_q
                 & ~cs_fall & ~cs_rise;
  assign ev_fall = (state_q == ACTIVE) & ~sclk_s & sclk_prev_q
                 & ~cs_fall & ~cs_rise;

  assign in_addr = (bit_cnt_q >= ADDR_LO) && (bit_cnt_q <= ADDR_HI);

  always_comb begin
    sel_sample = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (chan_q == ADDR_BITS'(k)) begin
        sel_sample = i_Samples[k*DATA_W +: DATA_W];
      end
    end
  end

  assign load_word = {{LEAD_ZEROS{1'b0}}, sel_sample};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    addr_sh_d = addr_sh_q;
    chan_d    = chan_q;
    reload_d  = reload_q;
    en_d      = en_q;
    done_d    = 1'b0;
    unique case (1'b1)
      cs_fall: begin
        state_d   = ACTIVE;
        shift_d   = load_word;
        bit_cnt_d = '0;
        reload_d  = 1'b0;
        en_d      = 1'b1;
      end
      cs_rise: begin
        state_d   = IDLE;
        shift_d   = '0;
        bit_cnt_d = '0;
        reload_d  = 1'b0;
        en_d      = 1'b0;
      end
      ev_rise: begin
        if (in_addr) begin
          addr_sh_d = {addr_sh_q[ADDR_BITS-2:0], mosi_s};
        end
        if (bit_cnt_q == LAST_BIT) begin
          chan_d    = addr_sh_q;
          done_d    = 1'b1;
          bit_cnt_d = '0;
          reload_d  = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ev_fall: begin
        if (reload_q) begin
          shift_d  = load_word;
          reload_d = 1'b0;
        end else begin
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      addr_sh_q   <= '0;
      chan_q      <= '0;
      reload_q    <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_sh_q   <= addr_sh_d;
      chan_q      <= chan_d;
      reload_q    <= reload_d;
      en_q        <= en_d;
      done_q      <= done_d;
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign o_SPI_MISO   = shift_q[FRAME_BITS-1];
  assign o_MISO_En    = en_q;
  assign o_Channel    = chan_q;
  assign o_Frame_Done = done_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench for adc_spi_responder.
// A mode-0 master model drives frames; words are checked per frame.
module tb_adc_spi_responder;

  localparam int KNONE  = 0;
  localparam int KABORT = 1;
  localparam int KCOLL  = 2;
  localparam int KRST   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic [95:0] samples;
  logic        miso;
  logic        miso_en;
  logic [2:0]  chan;
  logic        done;

  logic [11:0] smp [8];
  logic [15:0] exp_q [$];
  logic [2:0]  ch_m;
  int          done_cnt = 0;
  int          n_checks = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    samples = '0;
    for (int k = 0; k < 8; k++) begin
      samples[k*12 +: 12] = smp[k];
    end
  end

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  adc_spi_responder dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_SPI_Clk   (sclk),
    .i_SPI_CS_n  (cs_n),
    .i_SPI_MOSI  (mosi),
    .i_Samples   (samples),
    .o_SPI_MISO  (miso),
    .o_MISO_En   (miso_en),
    .o_Channel   (chan),
    .o_Frame_Done(done)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic frame(input logic [7:0]  addr,
                       input int          stop_at,
                       input int          kind,
                       input int          chg_at,
                       input logic [11:0] chg_val);
    logic [15:0] tx;
    logic [15:0] rx;
    logic [15:0] exp_w;
    int          d0;
    tx = {addr, 8'h00};
    rx = '0;
    d0 = done_cnt;
    exp_q.push_back({4'h0, smp[ch_m]});
    for (int i = 1; i <= 16; i++) begin
      mosi = tx[16-i];
      wait_clk(5);
      rx[16-i] = miso;
      if (i == stop_at && kind == KCOLL) begin
        cs_n = 1'b1;
        sclk = 1'b1;
        wait_clk(5);
        sclk = 1'b0;
        wait_clk(5);
        check("coll_done", done_cnt - d0, 0);
        check("coll_chan", 32'(chan), 32'(ch_m));
        void'(exp_q.pop_back());
        return;
      end
      sclk = 1'b1;
      if (i == chg_at) smp[0] = chg_val;
      if (i == stop_at && kind == KABORT) begin
        wait_clk(2);
        cs_n = 1'b1;
        wait_clk(3);
        check("abort_en", 32'(miso_en), 0);
        check("abort_miso", 32'(miso), 0);
        wait_clk(2);
        sclk = 1'b0;
        wait_clk(5);
        check("abort_done", done_cnt - d0, 0);
        check("abort_chan", 32'(chan), 32'(ch_m));
        void'(exp_q.pop_back());
        return;
      end
      if (i == stop_at && kind == KRST) begin
        wait_clk(2);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        #1;
        check("rst_miso", 32'(miso), 0);
        check("rst_en", 32'(miso_en), 0);
        check("rst_chan", 32'(chan), 0);
        check("rst_done", 32'(done), 0);
        sclk = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        ch_m  = '0;
        void'(exp_q.pop_back());
        wait_clk(3);
        return;
      end
      wait_clk(5);
      sclk = 1'b0;
    end
    check("frame_done", done_cnt - d0, 1);
    ch_m = addr[5:3];
    check("frame_chan", 32'(chan), 32'(ch_m));
    exp_w = exp_q.pop_front();
    check("frame_word", 32'(rx), 32'(exp_w));
  endtask

  task automatic cs_up();
    cs_n = 1'b1;
    wait_clk(6);
    check("idle_en", 32'(miso_en), 0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) smp[k] = '0;
    smp[0] = 12'hABC;
    smp[3] = 12'h123;
    smp[7] = 12'hFFF;
    ch_m  = '0;
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    wait_clk(3);
    check("reset_miso", 32'(miso), 0);
    check("reset_en", 32'(miso_en), 0);
    check("reset_chan", 32'(chan), 0);
    check("reset_done", 32'(done), 0);
    rst_n = 1'b1;
    wait_clk(5);
    check("post_rst_en", 32'(miso_en), 0);

    cs_n = 1'b0;
    frame(8'h18, 0, KNONE, 0, '0);
    cs_up();

    cs_n = 1'b0;
    frame(8'h38, 0, KNONE, 0, '0);
    frame(8'h00, 0, KNONE, 0, '0);
    frame(8'h18, 0, KNONE, 0, '0);
    cs_up();

    cs_n = 1'b0;
    frame(8'h00, 7, KABORT, 0, '0);
    wait_clk(6);
    cs_n = 1'b0;
    frame(8'h18, 0, KNONE, 0, '0);
    cs_up();

    smp[0] = 12'h555;
    cs_n = 1'b0;
    frame(8'h00, 0, KNONE, 0, '0);
    frame(8'h00, 0, KNONE, 5, 12'hAAA);
    frame(8'h00, 0, KNONE, 0, '0);
    cs_up();

    cs_n = 1'b0;
    frame(8'h38, 16, KCOLL, 0, '0);
    wait_clk(6);

    cs_n = 1'b0;
    frame(8'h38, 6, KRST, 0, '0);
    cs_n = 1'b0;
    frame(8'h18, 0, KNONE, 0, '0);
    cs_up();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
